// File: rtl/pe_queue_merger.sv
// Purpose : merges up to NQ column-sorted partial-product queues into one sparse output row,
//           summing entries that share a column; optional saturating sum under MERGE_SAT_EN.
// Latency : one pop per cycle; an entry leaves one cycle after the first pop of a different column.
// Backpr. : stalls (no pop) until every active queue head is valid; holds output while !out_ready.
module pe_queue_merger #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 16,
   parameter int NQ     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [IDX_W-1:0]     start_row,
   input  logic [NQ-1:0]        q_mask,
   output logic                 busy,
   input  logic [NQ-1:0]        q_valid,
   output logic [NQ-1:0]        q_ready,
   input  logic [NQ*DATA_W-1:0] q_val,
   input  logic [NQ*IDX_W-1:0]  q_col,
   input  logic [NQ-1:0]        q_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_val,
   output logic [IDX_W-1:0]     out_row,
   output logic [IDX_W-1:0]     out_col,
   output logic                 out_last,
   output logic                 row_done
);

   localparam int SW = (NQ > 1) ? $clog2(NQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MERGE,
      S_DRAIN,
      S_WAIT,
      S_DONE
   } state_t;

   state_t              state_q;
   logic [NQ-1:0]       mask_q;
   logic                acc_vld_q;
   logic [DATA_W-1:0]   acc_val_q;
   logic [IDX_W-1:0]    acc_col_q;
   logic                out_valid_q;
   logic [DATA_W-1:0]   out_val_q;
   logic [IDX_W-1:0]    out_row_q;
   logic [IDX_W-1:0]    out_col_q;
   logic                out_last_q;
   logic                row_done_q;

   logic                sel_found;
   logic [SW-1:0]       sel_idx;
   logic [IDX_W-1:0]    sel_col;
   logic [DATA_W-1:0]   sel_val;
   logic                sel_last;
   logic                all_vld;
   logic                out_free;
   logic                col_match;
   logic                pop;
   logic [NQ-1:0]       mask_d;
   logic [DATA_W-1:0]   sum_wrap;
   logic [DATA_W-1:0]   sum_d;

   // Pick the active queue with the smallest head column; strict '<' keeps the lowest index on ties.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_col   = '0;
      sel_val   = '0;
      sel_last  = 1'b0;
      all_vld   = 1'b1;
      for (int i = 0; i < NQ; i++) begin
         if (mask_q[i]) begin
            if (!q_valid[i]) all_vld = 1'b0;
            if (!sel_found || (q_col[i*IDX_W +: IDX_W] < sel_col)) begin
               sel_found = 1'b1;
               sel_idx   = SW'(i);
               sel_col   = q_col[i*IDX_W +: IDX_W];
               sel_val   = q_val[i*DATA_W +: DATA_W];
               sel_last  = q_last[i];
            end
         end
      end
   end

   assign out_free  = !out_valid_q || out_ready;
   assign col_match = acc_vld_q && (acc_col_q == sel_col);
   // A pop is safe whenever it cannot require pushing the accumulator into a busy output register.
   assign pop       = (state_q == S_MERGE) && sel_found && all_vld &&
                      (!acc_vld_q || col_match || out_free);
   assign q_ready   = pop ? (NQ'(1) << sel_idx) : '0;

   // Retire a queue from the active set when its last entry is popped.
   always_comb begin
      mask_d = mask_q;
      if (pop && sel_last) mask_d[sel_idx] = 1'b0;
   end

   assign sum_wrap = acc_val_q + sel_val;

   // Same-column accumulation: wrapping by default, clamped to the signed range when saturating.
   always_comb begin
      sum_d = sum_wrap;
`ifdef MERGE_SAT_EN
      if ((acc_val_q[DATA_W-1] == sel_val[DATA_W-1]) &&
          (sum_wrap[DATA_W-1] != acc_val_q[DATA_W-1])) begin
         sum_d = acc_val_q[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}};
      end
`else
      sum_d = sum_wrap;
`endif
   end

   // Row FSM, accumulator and output register; a consume clears out_valid unless a load overrides it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mask_q      <= '0;
         acc_vld_q   <= 1'b0;
         acc_val_q   <= '0;
         acc_col_q   <= '0;
         out_valid_q <= 1'b0;
         out_val_q   <= '0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         out_last_q  <= 1'b0;
         row_done_q  <= 1'b0;
      end else begin
         row_done_q <= 1'b0;
         if (out_valid_q && out_ready) out_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  out_row_q <= start_row;
                  mask_q    <= q_mask;
                  state_q   <= (q_mask == '0) ? S_DONE : S_MERGE;
               end
            end
            S_MERGE: begin
               if (pop) begin
                  mask_q <= mask_d;
                  if (col_match) begin
                     acc_val_q <= sum_d;
                  end else begin
                     if (acc_vld_q) begin
                        out_valid_q <= 1'b1;
                        out_val_q   <= acc_val_q;
                        out_col_q   <= acc_col_q;
                        out_last_q  <= 1'b0;
                     end
                     acc_vld_q <= 1'b1;
                     acc_val_q <= sel_val;
                     acc_col_q <= sel_col;
                  end
                  if (mask_d == '0) state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (out_free) begin
                  out_valid_q <= 1'b1;
                  out_val_q   <= acc_val_q;
                  out_col_q   <= acc_col_q;
                  out_last_q  <= 1'b1;
                  acc_vld_q   <= 1'b0;
                  state_q     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (out_valid_q && out_ready) state_q <= S_DONE;
            end
            S_DONE: begin
               row_done_q <= 1'b1;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign out_valid = out_valid_q;
   assign out_val   = out_val_q;
   assign out_row   = out_row_q;
   assign out_col   = out_col_q;
   assign out_last  = out_last_q;
   assign row_done  = row_done_q;

endmodule

// File: doc/pe_queue_merger.md
Name: pe_queue_merger

Overview:
- Drain side of the PE queue bank: reads up to NQ column-sorted queues, each holding one partial-product vector of the current output row.
- Merges them in ascending column order and sums entries whose columns match.
- Emits the finished sparse output row as a (val,row,col,last) stream.
- Sits between the queue bank written by the PE fill logic and the writeback path.

Parameters:
DATA_W, 32, value width (two's complement)
IDX_W, 16, row/column index width
NQ, 8, number of input queues

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin merging a row; accepted only in IDLE
start_row  in  IDX_W  row id of the merge, latched on accepted start
q_mask  in  NQ  queues participating in this row, latched on accepted start
busy  out  1  high in any state other than IDLE
q_valid  in  NQ  queue head valid, one bit per queue
q_ready  out  NQ  pop strobe, at most one bit high per cycle
q_val  in  NQ*DATA_W  head values, queue i at bits [i*DATA_W +: DATA_W]
q_col  in  NQ*IDX_W  head columns, same packing
q_last  in  NQ  head is the final entry of that queue's vector
out_valid  out  1  output entry valid
out_ready  in  1  downstream accept
out_val  out  DATA_W  merged value
out_row  out  IDX_W  latched row id
out_col  out  IDX_W  merged column
out_last  out  1  final entry of the row
row_done  out  1  one-cycle pulse after the row completes

Behaviour:
- Reset: state=IDLE, active mask=0, accumulator invalid, busy=0, q_ready=0, out_valid=0, out_val/out_row/out_col=0, out_last=0, row_done=0.
- Reset mid-row discards all state. No pop is issued while rst_n is low.
- IDLE:
  - On start: latch start_row into out_row and q_mask into the active mask.
  - q_mask==0: go to DONE.
  - Otherwise go to MERGE.
- MERGE, select:
  - The select step proceeds only when every active queue has q_valid=1; otherwise stall with q_ready=0.
  - Select the active queue with the minimum q_col (unsigned compare). Ties go to the lowest index.
- MERGE, pop condition: the selected queue is popped (one-hot q_ready) in the same cycle when:
  - (a) the accumulator is invalid, or
  - (b) the accumulator column equals the selected column, or
  - (c) the output register is free (!out_valid || out_ready).
- MERGE, accumulator update on a pop:
  - Case (b): accumulator value += q_val, wrapping mod 2^DATA_W.
  - Otherwise: the old accumulator, if valid, moves into the output register with out_last=0. The accumulator is then loaded with the selected value and column.
  - Popping an entry with q_last=1 clears that queue's active bit.
- MERGE exit: when the active mask becomes 0, go to DRAIN.
- DRAIN:
  - When the output register is free, load the accumulator with out_last=1, invalidate the accumulator, and go to WAIT.
- WAIT: once out_valid && out_ready for the last entry, go to DONE.
- DONE: row_done=1 for one cycle, then go to IDLE. busy drops in the IDLE cycle.
- Output register:
  - Payload is held stable while out_valid && !out_ready.
  - Load and consume may occur in the same cycle.
  - Throughput is one pop per cycle. Output latency is one cycle after the first pop with a different column.
- Output rows are strictly ascending in column with no duplicate columns. There is exactly one out_last per non-empty row.
- start while busy is ignored.

Optional Feature:
- Macro MERGE_SAT_EN.
- Defined: accumulation is signed saturating. Positive overflow gives 2^(DATA_W-1)-1; negative overflow gives -2^(DATA_W-1).
- Undefined: accumulation wraps modulo 2^DATA_W.

Test Plan:
- Test 1:
  - Stimulus: q_mask=0b011; q0={(c1,5),(c4,2,last)}; q1={(c2,3),(c4,7,last)}; start_row=9; out_ready=1.
  - Required: out=(9,1,5),(9,2,3),(9,4,9,last=1), then a row_done pulse; busy=0 afterwards.
- Test 2:
  - Stimulus: three queues each hold a single (c6,1,last) entry.
  - Required: a single output (c6,3,last=1); q_ready pops in queue order 0,1,2.
- Test 3:
  - Stimulus: q_mask=0; start.
  - Required: no out_valid; row_done pulses 2 cycles after start; q_ready stays 0.
- Test 4:
  - Stimulus: hold out_ready=0 for 5 cycles during test 1.
  - Required: out_* stable; at most one further pop, a same-column or first-load pop only; no entries lost.
- Test 5:
  - Stimulus: drop q1 q_valid for 3 cycles mid-merge.
  - Required: q_ready=0 throughout the stall; the result is identical to test 1.
- Test 6:
  - Stimulus: DATA_W=8; entries (c0,100) and (c0,100).
  - Required: with MERGE_SAT_EN, out_val=127; without it, out_val=-56.
  - Then assert rst_n mid-row: all outputs return to their reset values immediately.
